// File: rtl/usb_frame_loader.sv
// USB stream frame loader: hunts for SYNC headers, writes CA/MSG payloads to the
// channel RAMs, stages DELAY payloads, and checks the XOR trailer of every frame.
module usb_frame_loader #(
  parameter logic [15:0] SYNC      = 16'hCA5E,
  parameter int unsigned CA_WORDS  = 32,
  parameter int unsigned MSG_WORDS = 47
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] din,
  input  logic        din_valid,
  output logic        din_ready,
  output logic [31:0] data,
  output logic [15:0] wren,
  output logic [4:0]  wraddr_ca,
  output logic [5:0]  wraddr_msg,
  output logic [79:0] delay_ca,
  output logic        frame_done,
  output logic        crc_err,
  output logic [7:0]  err_cnt
);

  typedef enum logic [1:0] {HUNT, PAYLOAD, TRAILER, DONE} state_e;
  typedef enum logic [1:0] {FT_CA, FT_MSG, FT_DELAY, FT_BAD} ftype_e;

  localparam logic [5:0] CA_LAST  = 6'(CA_WORDS - 1);
  localparam logic [5:0] MSG_LAST = 6'(MSG_WORDS - 1);

  state_e       state_q, state_d;
  ftype_e       type_q;
  logic [2:0]   ch_q;
  logic [5:0]   cnt_q;
  logic [31:0]  csum_q;
  logic [9:0]   stage_q;
  logic [31:0]  data_q;
  logic [15:0]  wren_q;
  logic [4:0]   wraddr_ca_q;
  logic [5:0]   wraddr_msg_q;
  logic [79:0]  delay_q;
  logic         frame_done_q;
  logic         crc_err_q;
  logic [7:0]   err_cnt_q;

  logic         accept;
  logic         is_sync;
  ftype_e       hdr_type;
  logic [5:0]   last_idx;
  logic         payload_last;
  logic         err_inc;

  assign accept   = din_valid & din_ready;
  assign is_sync  = (din[31:16] == SYNC);
  assign hdr_type = ftype_e'(din[5:4]);

  always_comb begin
    last_idx = 6'd0;
    case (type_q)
      FT_CA:   last_idx = CA_LAST;
      FT_MSG:  last_idx = MSG_LAST;
      default: last_idx = 6'd0;
    endcase
  end

  assign payload_last = (cnt_q == last_idx);

  // Both invalid headers and checksum failures feed the same saturating counter.
  assign err_inc = accept &&
                   (((state_q == HUNT) && is_sync && (hdr_type == FT_BAD)) ||
                    ((state_q == TRAILER) && (din != csum_q)));

  always_ff @(posedge clk) begin
    if (rst) state_q <= HUNT;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      HUNT:    if (accept && is_sync && (hdr_type != FT_BAD)) state_d = PAYLOAD;
      PAYLOAD: if (accept && payload_last) state_d = TRAILER;
      TRAILER: if (accept) state_d = DONE;
      DONE:    state_d = HUNT;
      default: state_d = HUNT;
    endcase
  end

  always_comb begin
    din_ready = ~rst && (state_q != DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      type_q       <= FT_CA;
      ch_q         <= 3'd0;
      cnt_q        <= 6'd0;
      csum_q       <= 32'd0;
      stage_q      <= 10'd0;
      data_q       <= 32'd0;
      wren_q       <= 16'd0;
      wraddr_ca_q  <= 5'd0;
      wraddr_msg_q <= 6'd0;
      delay_q      <= 80'd0;
      frame_done_q <= 1'b0;
      crc_err_q    <= 1'b0;
      err_cnt_q    <= 8'd0;
    end else begin
      wren_q       <= 16'd0;
      frame_done_q <= 1'b0;
      crc_err_q    <= 1'b0;

      if (err_inc && (err_cnt_q != 8'hFF)) err_cnt_q <= err_cnt_q + 8'd1;

      case (state_q)
        HUNT: begin
          if (accept && is_sync && (hdr_type != FT_BAD)) begin
            type_q       <= hdr_type;
            ch_q         <= din[2:0];
            cnt_q        <= 6'd0;
            csum_q       <= din;
            wraddr_ca_q  <= 5'd0;
            wraddr_msg_q <= 6'd0;
          end
        end
        PAYLOAD: begin
          if (accept) begin
            csum_q <= csum_q ^ din;
            cnt_q  <= cnt_q + 6'd1;
            case (type_q)
              FT_CA: begin
                data_q            <= din;
                wren_q[{1'b0, ch_q}] <= 1'b1;
                wraddr_ca_q       <= cnt_q[4:0];
              end
              FT_MSG: begin
                data_q            <= din;
                wren_q[{1'b1, ch_q}] <= 1'b1;
                wraddr_msg_q      <= cnt_q;
              end
              default: begin
                // 1023 is clamped to 1022 here so the commit is a plain copy.
                stage_q <= (din[9:0] == 10'h3FF) ? 10'd1022 : din[9:0];
              end
            endcase
          end
        end
        TRAILER: begin
          if (accept) begin
            if (din == csum_q) begin
              frame_done_q <= 1'b1;
              if (type_q == FT_DELAY) begin
                for (int i = 0; i < 8; i++) begin
                  if (ch_q == 3'(i)) delay_q[i*10 +: 10] <= stage_q;
                end
              end
            end else begin
              crc_err_q <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign data       = data_q;
  assign wren       = wren_q;
  assign wraddr_ca  = wraddr_ca_q;
  assign wraddr_msg = wraddr_msg_q;
  assign delay_ca   = delay_q;
  assign frame_done = frame_done_q;
  assign crc_err    = crc_err_q;
  assign err_cnt    = err_cnt_q;

endmodule
